// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Brief    : Shared types for the instruction/data memory port arbiter:
//             one-hot FSM state encoding and port owner encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Width of the streak counter; MAX_STREAK is limited to 1..15.
    localparam int unsigned c_STREAK_W = 4;

    // One-hot FSM states, 6 bits wide.
    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_I_REQ = 6'b000010,
        ST_I_RSP = 6'b000100,
        ST_D_WR  = 6'b001000,
        ST_D_RD  = 6'b010000,
        ST_D_RSP = 6'b100000
    } state_t;

    // Which requester owns the downstream port.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Instruction, data and downstream memory channels plus the
//             performance counters of the memory port arbiter. The master
//             modport is the arbiter's view; slave is the surroundings.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    // Instruction fetch channel
    logic [31:0] i_req_addr;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_rready;
    // Data channel
    logic [31:0] d_addr;
    logic        d_wen;
    logic        d_ren;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_req_ready;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_rready;
    // Downstream memory port
    logic [31:0] m_addr;
    logic        m_wen;
    logic        m_ren;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_req_ready;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rready;
    // Performance counters
    logic [31:0] cnt_i_grant;
    logic [31:0] cnt_d_grant;
    logic [31:0] cnt_stall;

    modport master (
        input  i_req_addr, i_req_valid, i_rready,
        input  d_addr, d_wen, d_ren, d_wdata, d_wstrb, d_rready,
        input  m_req_ready, m_rdata, m_rvalid,
        output i_req_ready, i_rdata, i_rvalid,
        output d_req_ready, d_rdata, d_rvalid,
        output m_addr, m_wen, m_ren, m_wdata, m_wstrb, m_rready,
        output cnt_i_grant, cnt_d_grant, cnt_stall
    );

    modport slave (
        output i_req_addr, i_req_valid, i_rready,
        output d_addr, d_wen, d_ren, d_wdata, d_wstrb, d_rready,
        output m_req_ready, m_rdata, m_rvalid,
        input  i_req_ready, i_rdata, i_rvalid,
        input  d_req_ready, d_rdata, d_rvalid,
        input  m_addr, m_wen, m_ren, m_wdata, m_wstrb, m_rready,
        input  cnt_i_grant, cnt_d_grant, cnt_stall
    );
endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_prio_pick.sv
`default_nettype none
// ============================================================================
//  Module   : arb_prio_pick
//  Brief    : Two-input fixed-priority pick with a fairness override: when
//             both sides request and the priority side has used up its
//             streak, the other side wins. Purely combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_prio_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_PRIO = 1
) (
    input  wire logic i_i_pend,
    input  wire logic i_d_pend,
    input  wire logic i_streak_full,
    output owner_t    o_owner,
    output logic      o_grant
);

    localparam logic c_PRIO_D = (DATA_PRIO != 0);

    // Pick the winner; a full streak flips the priority for this grant only.
    always_comb begin
        o_grant = i_i_pend | i_d_pend;
        o_owner = OWN_I;
        if (i_i_pend && i_d_pend) begin
            o_owner = (c_PRIO_D != i_streak_full) ? OWN_D : OWN_I;
        end else if (i_d_pend) begin
            o_owner = OWN_D;
        end
    end

endmodule : arb_prio_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one downstream memory port between the CPU instruction
//             and data channels. Grants one side at a time, holds the grant
//             until the transaction completes, routes read data back to the
//             owner and counts grants and stall cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_PRIO  = 1,
    parameter int MAX_STREAK = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.master bus
);

    localparam logic [c_STREAK_W-1:0] c_MAX_STREAK = c_STREAK_W'(MAX_STREAK);
    localparam owner_t                c_PRIO_OWNER = (DATA_PRIO != 0) ? OWN_D : OWN_I;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_STREAK_W-1:0] r_streak;
    logic [c_STREAK_W-1:0] w_streak_nxt;
    logic [31:0]           r_cnt_i;
    logic [31:0]           r_cnt_d;
    logic [31:0]           r_cnt_stall;

    logic   w_i_pend;
    logic   w_d_pend;
    logic   w_streak_full;
    logic   w_pick_grant;
    owner_t w_pick_owner;
    logic   w_take_i;
    logic   w_take_d;
    logic   w_d_owns;
    logic   w_stall;

    assign w_i_pend      = bus.i_req_valid;
    assign w_d_pend      = bus.d_wen | bus.d_ren;
    assign w_streak_full = (r_streak == c_MAX_STREAK);

    arb_prio_pick #(
        .DATA_PRIO (DATA_PRIO)
    ) u_pick (
        .i_i_pend      (w_i_pend),
        .i_d_pend      (w_d_pend),
        .i_streak_full (w_streak_full),
        .o_owner       (w_pick_owner),
        .o_grant       (w_pick_grant)
    );

    // Owner is implied by the registered state, so the m_* muxes never see request valids.
    assign w_d_owns = (r_state == ST_D_WR) || (r_state == ST_D_RD) || (r_state == ST_D_RSP);
    assign w_stall  = (r_state != ST_IDLE) && (w_d_owns ? w_i_pend : w_d_pend);

    // State and streak registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    // Next-state logic and per-state routing between requesters and the memory port.
    always_comb begin
        w_state_nxt     = r_state;
        w_streak_nxt    = r_streak;
        w_take_i        = 1'b0;
        w_take_d        = 1'b0;
        bus.i_req_ready = 1'b0;
        bus.i_rdata     = '0;
        bus.i_rvalid    = 1'b0;
        bus.d_req_ready = 1'b0;
        bus.d_rdata     = '0;
        bus.d_rvalid    = 1'b0;
        bus.m_addr      = '0;
        bus.m_wen       = 1'b0;
        bus.m_ren       = 1'b0;
        bus.m_wdata     = '0;
        bus.m_wstrb     = '0;
        bus.m_rready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_grant) begin
                    if (w_pick_owner == OWN_D) begin
                        w_take_d    = 1'b1;
                        w_state_nxt = bus.d_wen ? ST_D_WR : ST_D_RD;
                    end else begin
                        w_take_i    = 1'b1;
                        w_state_nxt = ST_I_REQ;
                    end
                    // Streak grows only when the priority side beats a waiting rival.
                    if (w_i_pend && w_d_pend && (w_pick_owner == c_PRIO_OWNER)) begin
                        w_streak_nxt = w_streak_full ? r_streak : r_streak + 1'b1;
                    end else begin
                        w_streak_nxt = '0;
                    end
                end
            end
            ST_I_REQ: begin
                bus.m_ren       = 1'b1;
                bus.m_addr      = bus.i_req_addr;
                bus.i_req_ready = bus.m_req_ready;
                if (bus.m_req_ready) w_state_nxt = ST_I_RSP;
            end
            ST_I_RSP: begin
                bus.i_rvalid = bus.m_rvalid;
                bus.i_rdata  = bus.m_rdata;
                bus.m_rready = bus.i_rready;
                if (bus.m_rvalid && bus.i_rready) w_state_nxt = ST_IDLE;
            end
            ST_D_WR: begin
                bus.m_wen       = 1'b1;
                bus.m_addr      = bus.d_addr;
                bus.m_wdata     = bus.d_wdata;
                bus.m_wstrb     = bus.d_wstrb;
                bus.d_req_ready = bus.m_req_ready;
                if (bus.m_req_ready) w_state_nxt = ST_IDLE;
            end
            ST_D_RD: begin
                bus.m_ren       = 1'b1;
                bus.m_addr      = bus.d_addr;
                bus.d_req_ready = bus.m_req_ready;
                if (bus.m_req_ready) w_state_nxt = ST_D_RSP;
            end
            ST_D_RSP: begin
                bus.d_rvalid = bus.m_rvalid;
                bus.d_rdata  = bus.m_rdata;
                bus.m_rready = bus.d_rready;
                if (bus.m_rvalid && bus.d_rready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant and stall performance counters, free-running modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_i     <= '0;
            r_cnt_d     <= '0;
            r_cnt_stall <= '0;
        end else begin
            if (w_take_i) r_cnt_i     <= r_cnt_i + 32'd1;
            if (w_take_d) r_cnt_d     <= r_cnt_d + 32'd1;
            if (w_stall)  r_cnt_stall <= r_cnt_stall + 32'd1;
        end
    end

    assign bus.cnt_i_grant = r_cnt_i;
    assign bus.cnt_d_grant = r_cnt_d;
    assign bus.cnt_stall   = r_cnt_stall;

endmodule : mem_port_arbiter
`default_nettype wire
